// File: rtl/vga_cursor_overlay.sv
// Hardware cursor compositor: rebuilds the beam position from the upstream syncs and
// overlays a 16x16 2bpp bitmap cursor, with a fixed 2-cycle latency on pixels and syncs.
module vga_cursor_overlay #(
  parameter int PIXEL_WIDTH  = 640,
  parameter int PIXEL_HEIGHT = 480,
  parameter int H_SYNC_PULSE = 96,
  parameter int H_BACK_PORCH = 48,
  parameter int V_SYNC_PULSE = 2,
  parameter int V_BACK_PORCH = 33,
  parameter int H_OFFSET     = 0,
  parameter bit SYNC_ACTIVE  = 1'b0
) (
  input  logic        pxclk,
  input  logic        rst_n,
  input  logic [3:0]  in_r,
  input  logic [3:0]  in_g,
  input  logic [3:0]  in_b,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        cur_en,
  input  logic [9:0]  cur_x,
  input  logic [9:0]  cur_y,
  input  logic [11:0] cur_col0,
  input  logic [11:0] cur_col1,
  input  logic        bmp_we,
  input  logic [3:0]  bmp_row,
  input  logic [31:0] bmp_wdata,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync
);

  localparam logic signed [11:0] H_START_S = 12'(H_SYNC_PULSE + H_BACK_PORCH + H_OFFSET);
  localparam logic signed [11:0] V_START_S = 12'(V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic signed [11:0] WIDTH_S   = 12'(PIXEL_WIDTH);
  localparam logic signed [11:0] HEIGHT_S  = 12'(PIXEL_HEIGHT);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic        hs_d, vs_d;
  logic        hs_edge, vs_edge;
  logic [10:0] hcnt_q, hcnt_cur;
  logic [9:0]  vcnt_q, vcnt_cur;

  logic        sh_en;
  logic [9:0]  sh_x, sh_y;
  logic [11:0] sh_col0, sh_col1;

  logic [31:0] bmp_mem [16];
  logic [31:0] row_data;

  logic signed [11:0] x_s, y_s, dx_s, dy_s;
  logic        visible, hit;
  logic [1:0]  code;

  logic [11:0] rgb_p1;
  logic        hs_p1, vs_p1, hit_p1;
  logic [1:0]  code_p1;
  logic [11:0] pix_mux;

  // Beam position: counters restart on sync assertion edges; vsync wins on a tie
  always_comb begin
    hs_edge  = (in_hsync == SYNC_ACTIVE) && (hs_d != SYNC_ACTIVE);
    vs_edge  = (in_vsync == SYNC_ACTIVE) && (vs_d != SYNC_ACTIVE);
    hcnt_cur = hs_edge ? 11'd0 : sat_inc11(hcnt_q);
    if (vs_edge)      vcnt_cur = 10'd0;
    else if (hs_edge) vcnt_cur = sat_inc10(vcnt_q);
    else              vcnt_cur = vcnt_q;
  end

  // Syncs reset to the active level so a sync already asserted at release is not an edge
  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      hs_d    <= SYNC_ACTIVE;
      vs_d    <= SYNC_ACTIVE;
      hcnt_q  <= 11'h7FF;
      vcnt_q  <= 10'h3FF;
      sh_en   <= 1'b0;
      sh_x    <= '0;
      sh_y    <= '0;
      sh_col0 <= '0;
      sh_col1 <= '0;
    end else begin
      hs_d   <= in_hsync;
      vs_d   <= in_vsync;
      hcnt_q <= hcnt_cur;
      vcnt_q <= vcnt_cur;
      if (vs_edge) begin
        sh_en   <= cur_en;
        sh_x    <= cur_x;
        sh_y    <= cur_y;
        sh_col0 <= cur_col0;
        sh_col1 <= cur_col1;
      end
    end
  end

  always_ff @(posedge pxclk) begin
    if (bmp_we) bmp_mem[bmp_row] <= bmp_wdata;
  end

  // Signed differences make off-screen cursor placements clip instead of wrapping
  always_comb begin
    x_s      = $signed({1'b0, hcnt_cur}) - H_START_S;
    y_s      = $signed({2'b00, vcnt_cur}) - V_START_S;
    dx_s     = x_s - $signed({2'b00, sh_x});
    dy_s     = y_s - $signed({2'b00, sh_y});
    visible  = (x_s >= 12'sd0) && (x_s < WIDTH_S) && (y_s >= 12'sd0) && (y_s < HEIGHT_S);
    hit      = visible && sh_en && (dx_s >= 12'sd0) && (dx_s <= 12'sd15) &&
               (dy_s >= 12'sd0) && (dy_s <= 12'sd15);
    row_data = bmp_mem[dy_s[3:0]];
    code     = row_data[{dx_s[3:0], 1'b0} +: 2];
  end

  // Stage 1: input pixel, syncs, hit and bitmap code
  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      rgb_p1  <= '0;
      hs_p1   <= ~SYNC_ACTIVE;
      vs_p1   <= ~SYNC_ACTIVE;
      hit_p1  <= 1'b0;
      code_p1 <= 2'b00;
    end else begin
      rgb_p1  <= {in_r, in_g, in_b};
      hs_p1   <= in_hsync;
      vs_p1   <= in_vsync;
      hit_p1  <= hit;
      code_p1 <= code;
    end
  end

  always_comb begin
    pix_mux = rgb_p1;
    if (hit_p1) begin
      case (code_p1)
        2'b01:   pix_mux = sh_col0;
        2'b10:   pix_mux = sh_col1;
        2'b11:   pix_mux = ~rgb_p1;
        default: pix_mux = rgb_p1;
      endcase
    end
  end

  // Stage 2: composited colour and delayed syncs
  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= ~SYNC_ACTIVE;
      vsync <= ~SYNC_ACTIVE;
    end else begin
      {r, g, b} <= pix_mux;
      hsync     <= hs_p1;
      vsync     <= vs_p1;
    end
  end

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Bench for vga_cursor_overlay on a reduced 32x24 raster: frame-coordinate reference model
// with a 2-deep expectation queue, directed cursor scenarios and randomized frames.
module tb_vga_cursor_overlay;

  localparam int W = 32, H = 24;
  localparam int HS = 4, HBP = 4, HFP = 4, HO = 0;
  localparam int VS = 2, VBP = 3, VFP = 2;
  localparam int HT = HS + HBP + W + HFP;
  localparam int VT = VS + VBP + H + VFP;
  localparam bit SA = 1'b0;

  logic        pxclk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_r, in_g, in_b;
  logic        in_hsync, in_vsync;
  logic        cur_en;
  logic [9:0]  cur_x, cur_y;
  logic [11:0] cur_col0, cur_col1;
  logic        bmp_we;
  logic [3:0]  bmp_row;
  logic [31:0] bmp_wdata;
  logic [3:0]  r, g, b;
  logic        hsync, vsync;

  vga_cursor_overlay #(
    .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HBP),
    .V_SYNC_PULSE(VS), .V_BACK_PORCH(VBP), .H_OFFSET(HO), .SYNC_ACTIVE(SA)
  ) dut (
    .pxclk(pxclk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .cur_en(cur_en), .cur_x(cur_x), .cur_y(cur_y),
    .cur_col0(cur_col0), .cur_col1(cur_col1), .bmp_we(bmp_we), .bmp_row(bmp_row),
    .bmp_wdata(bmp_wdata), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
  );

  initial forever #5 pxclk = ~pxclk;

  typedef struct {
    logic [13:0] val;
    int          x;
    int          y;
    bit          onscr;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0, n_fail = 0;
  bit          h_lock, v_lock, m_en;
  int          m_cx, m_cy;
  logic [11:0] m_c0, m_c1;
  logic [31:0] m_bmp [16];
  logic [11:0] cap [H][W];
  logic [11:0] fix_pix;
  int          chg_line = -1;
  logic [9:0]  chg_x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One pixel clock: derive the expected output from screen coordinates, then compare
  // against what was predicted two samples ago.
  task automatic step(input int line, input int col);
    exp_t        e, f;
    logic [11:0] pin, pout;
    int          x, y, code;
    bit          rst_now;
    pin = {in_r, in_g, in_b};
    rst_now = !rst_n;
    if (rst_now) begin
      h_lock = 0; v_lock = 0; m_en = 0; m_cx = 0; m_cy = 0; m_c0 = '0; m_c1 = '0;
    end else if (col == 0) begin
      h_lock = 1;
      if (line == 0) begin
        v_lock = 1; m_en = cur_en; m_cx = int'(cur_x); m_cy = int'(cur_y);
        m_c0 = cur_col0; m_c1 = cur_col1;
      end
    end
    x = col - (HS + HBP + HO);
    y = line - (VS + VBP);
    e.onscr = (x >= 0) && (x < W) && (y >= 0) && (y < H);
    e.x = x; e.y = y;
    pout = pin;
    if (e.onscr && h_lock && v_lock && m_en &&
        x >= m_cx && x < m_cx + 16 && y >= m_cy && y < m_cy + 16) begin
      code = int'((m_bmp[y - m_cy] >> (2 * (x - m_cx))) & 32'd3);
      case (code)
        1: pout = m_c0;
        2: pout = m_c1;
        3: pout = ~pin;
        default: pout = pin;
      endcase
    end
    e.val = {pout, in_hsync, in_vsync};
    if (bmp_we) m_bmp[bmp_row] = bmp_wdata;
    @(posedge pxclk);
    #1;
    if (rst_now) begin
      q.delete();
      e.val = {12'h000, ~SA, ~SA};
      e.onscr = 0;
      q.push_back(e);
      chk("reset_out", 32'({r, g, b, hsync, vsync}), 32'(e.val));
    end else begin
      q.push_back(e);
      f = q.pop_front();
      chk("pixel_out", 32'({r, g, b, hsync, vsync}), 32'(f.val));
      if (f.onscr) cap[f.y][f.x] = {r, g, b};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_hsync = ~SA;
      in_vsync = ~SA;
      step(VT - 1, HS + HBP + W + 1);
    end
  endtask

  task automatic load_bmp(input logic [31:0] row0, input logic [31:0] rest);
    for (int i = 0; i < 16; i++) begin
      bmp_we = 1'b1;
      bmp_row = 4'(i);
      bmp_wdata = (i == 0) ? row0 : rest;
      idle(1);
    end
    bmp_we = 1'b0;
  endtask

  task automatic rand_cursor();
    cur_en   = ($urandom_range(0, 3) != 0);
    cur_x    = 10'($urandom_range(0, W + 4));
    cur_y    = 10'($urandom_range(0, H + 4));
    cur_col0 = 12'($urandom);
    cur_col1 = 12'($urandom);
  endtask

  task automatic run_frame(input bit rnd, input int rst_cyc);
    int cyc = 0;
    for (int line = 0; line < VT; line++) begin
      for (int col = 0; col < HT; col++) begin
        in_hsync = (col < HS) ? SA : ~SA;
        in_vsync = (line < VS) ? SA : ~SA;
        if (rnd) begin
          {in_r, in_g, in_b} = 12'($urandom);
          bmp_we    = ($urandom_range(0, 99) == 0);
          bmp_row   = 4'($urandom);
          bmp_wdata = $urandom;
          if ($urandom_range(0, 299) == 0) rand_cursor();
        end else begin
          {in_r, in_g, in_b} = fix_pix;
        end
        if (line == chg_line && col == 0) cur_x = chg_x;
        rst_n = !(cyc >= rst_cyc && cyc < rst_cyc + 3);
        step(line, col);
        cyc++;
      end
    end
    bmp_we = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic int count_col(input logic [11:0] c);
    int n = 0;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (cap[yy][xx] === c) n++;
    return n;
  endfunction

  initial begin
    rst_n = 1'b0;
    {in_r, in_g, in_b} = 12'hFFF;
    in_hsync = ~SA; in_vsync = ~SA;
    cur_en = 1'b0; cur_x = '0; cur_y = '0; cur_col0 = '0; cur_col1 = '0;
    bmp_we = 1'b0; bmp_row = '0; bmp_wdata = '0;
    fix_pix = 12'h000;
    idle(3);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {in_r, in_g, in_b} = 12'($urandom);
      idle(1);
    end

    // Basic draw with a solid code-01 bitmap at the top-left corner
    load_bmp(32'h5555_5555, 32'h5555_5555);
    cur_en = 1'b1; cur_x = 10'd0; cur_y = 10'd0; cur_col0 = 12'hF00; cur_col1 = 12'h0F0;
    fix_pix = 12'h000;
    run_frame(0, -10);
    chk("basic_0_0",   32'(cap[0][0]),   32'h F00);
    chk("basic_15_15", 32'(cap[15][15]), 32'h F00);
    chk("basic_x16",   32'(cap[0][16]),  32'h 000);
    chk("basic_y16",   32'(cap[16][0]),  32'h 000);

    // All four pixel codes on row 0
    load_bmp(32'h0000_00E4, 32'h0);
    fix_pix = 12'h123;
    run_frame(0, -10);
    chk("code_x0", 32'(cap[0][0]), 32'h123);
    chk("code_x1", 32'(cap[0][1]), 32'hF00);
    chk("code_x2", 32'(cap[0][2]), 32'h0F0);
    chk("code_x3", 32'(cap[0][3]), 32'hEDC);
    chk("code_x4", 32'(cap[0][4]), 32'h123);

    // Clipping at the bottom-right corner and fully off-screen placements
    load_bmp(32'h5555_5555, 32'h5555_5555);
    fix_pix = 12'h000;
    cur_x = 10'(W - 8); cur_y = 10'(H - 8);
    run_frame(0, -10);
    chk("clip_count",  32'(count_col(12'hF00)), 32'd64);
    chk("clip_nowrap", 32'(cap[0][0]), 32'h000);
    cur_x = 10'(W); cur_y = 10'd0;
    run_frame(0, -10);
    chk("offscr_x", 32'(count_col(12'hF00)), 32'd0);
    cur_x = 10'd0; cur_y = 10'(H);
    run_frame(0, -10);
    chk("offscr_y", 32'(count_col(12'hF00)), 32'd0);

    // Position change mid-frame takes effect only on the next frame
    cur_x = 10'd4; cur_y = 10'd8;
    chg_line = VS + VBP + 12; chg_x = 10'd12;
    run_frame(0, -10);
    chg_line = -1;
    chk("shadow_old_in",  32'(cap[20][4]),  32'hF00);
    chk("shadow_old_out", 32'(cap[20][20]), 32'h000);
    run_frame(0, -10);
    chk("shadow_new_in",  32'(cap[20][20]), 32'hF00);
    chk("shadow_new_out", 32'(cap[20][4]),  32'h000);

    // Reset mid-frame: passthrough until the next frame re-locks the counters
    cur_x = 10'd0; cur_y = 10'd0;
    run_frame(0, (VS + VBP + 2) * HT + 20);
    chk("mrst_before", 32'(cap[1][0]), 32'hF00);
    chk("mrst_after",  32'(cap[5][0]), 32'h000);
    run_frame(0, -10);
    chk("mrst_relock", 32'(cap[5][0]), 32'hF00);

    // Randomized frames: pixels, cursor settings and mid-frame bitmap writes
    for (int k = 0; k < 6; k++) begin
      rand_cursor();
      run_frame(1, (k == 3) ? (VS + VBP + 7) * HT + 15 : -10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
